// File: rtl/arm64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm64_pkg
// Description : Shared constants, types and helpers for the integer register
//               file and its issue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package arm64_pkg;

    // Architectural register width in bits
    localparam int ARM_DATA_W   = 64;
    // Width of a register index
    localparam int ARM_REG_AW   = 5;
    // Number of architectural register slots, including the zero register
    localparam int ARM_NUM_REGS = 32;
    // Index of the hardwired zero register (XZR)
    localparam int ARM_XZR_IDX  = 31;

    typedef logic [ARM_REG_AW-1:0]   reg_addr_t;
    typedef logic [ARM_NUM_REGS-1:0] reg_mask_t;

    // One-hot mask selecting a single register slot
    function automatic reg_mask_t reg_onehot(input reg_addr_t idx);
        reg_mask_t m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage : arm64_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard_decoder.sv
`default_nettype none
// ============================================================================
// Module      : Decoder5to32
// Description : 5-to-32 one-hot decoder with enable; all outputs low when
//               the enable is deasserted.
// Revision    : 1.0 - initial release
// ============================================================================
module Decoder5to32 (
    input  logic        en,
    input  logic [4:0]  sel,
    output logic [31:0] y
);

    // One-hot decode of sel, forced to zero when disabled
    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule : Decoder5to32
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : 31 x DATA_W integer register file plus hardwired zero
//               register, two combinational read ports with write-through
//               bypass, one write port, and a per-register pending scoreboard
//               that blocks a second issue to a register still awaiting
//               writeback (WAW hazard).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import arm64_pkg::*;
#(
    parameter int DATA_W   = ARM_DATA_W,
    parameter int NUM_REGS = ARM_NUM_REGS,
    parameter int XZR_IDX  = ARM_XZR_IDX
) (
    input  logic                  clk,
    input  logic                  rst,
    // Read port A
    input  logic [ARM_REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic                  pend_a,
    // Read port B
    input  logic [ARM_REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic                  pend_b,
    // Writeback port
    input  logic                  wr_en,
    input  logic [ARM_REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    // Issue port
    input  logic                  iss_en,
    input  logic [ARM_REG_AW-1:0] iss_addr,
    output logic                  iss_ok
);

    localparam reg_addr_t C_XZR_ADDR = reg_addr_t'(XZR_IDX);
    localparam reg_mask_t C_XZR_MASK = reg_mask_t'(1) << XZR_IDX;

    // ------------------------------------------------------------------------
    // Write-enable decode; reset suppresses every write strobe
    // ------------------------------------------------------------------------
    logic      wr_dec_en;
    reg_mask_t wr_onehot;

    assign wr_dec_en = wr_en & ~rst;

    Decoder5to32 u_wr_dec (
        .en  (wr_dec_en),
        .sel (wr_addr),
        .y   (wr_onehot)
    );

    // ------------------------------------------------------------------------
    // Storage: one register per slot, zero slot is a constant with no flops
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] rf_rd [NUM_REGS];

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            if (i == XZR_IDX) begin : g_xzr
                assign rf_rd[i] = '0;
            end else begin : g_data
                logic [DATA_W-1:0] data_q;

                // Register slot update: clear on reset, load on its write strobe
                always_ff @(posedge clk) begin
                    if (rst) begin
                        data_q <= '0;
                    end else if (wr_onehot[i]) begin
                        data_q <= wr_data;
                    end
                end

                assign rf_rd[i] = data_q;
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    reg_mask_t pend_q;
    reg_mask_t pend_d;
    reg_mask_t iss_set;
    logic      wr_hit_a;
    logic      wr_hit_b;
    logic      wr_hit_iss;

    // A writeback to a non-zero register matching each lookup address
    assign wr_hit_a   = wr_en && (wr_addr == rd_addr_a) && (rd_addr_a != C_XZR_ADDR);
    assign wr_hit_b   = wr_en && (wr_addr == rd_addr_b) && (rd_addr_b != C_XZR_ADDR);
    assign wr_hit_iss = wr_en && (wr_addr == iss_addr);

    // Issue is accepted when the destination is free, is XZR, or is being
    // written back this same cycle (the new owner takes over the slot)
    always_comb begin
        iss_ok = 1'b0;
        if (iss_en && !rst) begin
            iss_ok = (iss_addr == C_XZR_ADDR) || !pend_q[iss_addr] || wr_hit_iss;
        end
    end

    // Pending next state: clear on writeback, then set on accepted issue so a
    // same-cycle issue wins; the XZR slot never becomes pending
    always_comb begin
        iss_set = '0;
        if (iss_ok && (iss_addr != C_XZR_ADDR)) begin
            iss_set = reg_onehot(iss_addr);
        end
        pend_d = ((pend_q & ~wr_onehot) | iss_set) & ~C_XZR_MASK;
    end

    // Pending vector register
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports with write-through bypass and pending lookup
    // ------------------------------------------------------------------------
    // Port A data and pending flag
    always_comb begin
        rd_data_a = rf_rd[rd_addr_a];
        if (wr_hit_a) begin
            rd_data_a = wr_data;
        end
        pend_a = 1'b0;
        if (rd_addr_a != C_XZR_ADDR) begin
            pend_a = pend_q[rd_addr_a] & ~(wr_en && (wr_addr == rd_addr_a));
        end
    end

    // Port B data and pending flag
    always_comb begin
        rd_data_b = rf_rd[rd_addr_b];
        if (wr_hit_b) begin
            rd_data_b = wr_data;
        end
        pend_b = 1'b0;
        if (rd_addr_b != C_XZR_ADDR) begin
            pend_b = pend_q[rd_addr_b] & ~(wr_en && (wr_addr == rd_addr_b));
        end
    end

endmodule : regfile_scoreboard
`default_nettype wire
